// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo shared package
// Op codes, FSM state encoding and default width for the HI/LO unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // mult/div codes all have op[2]=0; op[0]=0 marks the signed variant
    function automatic logic op_is_arith(logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic op_is_signed(logic [2:0] op);
        return ~op[2] & ~op[0];
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo request/result interface
// Controller side is master; the HI/LO unit is slave.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo_step.sv
// mdu_step: one combinational multiply/divide iteration
// Mult: shift-add on {acc,shr}. Div: restoring shift-subtract.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] shr_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] shr_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   mtmp;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] sub;
    logic             ge;

    // Partial product add and the one-bit-wider trial remainder
    always_comb begin
        sum  = {1'b0, acc_i} + {1'b0, opb_i};
        mtmp = shr_i[0] ? sum : {1'b0, acc_i};
        rsh  = {acc_i, shr_i[WIDTH-1]};
        ge   = (rsh >= {1'b0, opb_i});
        sub  = rsh[WIDTH-1:0] - opb_i;
    end

    // Select the mult or div successor of {acc,shr}
    always_comb begin
        acc_o = mtmp[WIDTH:1];
        shr_o = {mtmp[0], shr_i[WIDTH-1:1]};
        if (div_i) begin
            acc_o = ge ? sub : rsh[WIDTH-1:0];
            shr_o = {shr_i[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with HI/LO registers
// IDLE accepts, CALC runs WIDTH steps, FIX applies signs and writes HI/LO.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic     clk,
    input  logic     rstn,
    mdu_hilo_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   shr_q, shr_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_acc, step_shr;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .shr_i (shr_q),
        .opb_i (opb_q),
        .acc_o (step_acc),
        .shr_o (step_shr)
    );

    // Operand magnitudes at accept and sign-corrected results at FIX
    always_comb begin
        a_neg  = op_is_signed(bus.op) & bus.a[WIDTH-1];
        b_neg  = op_is_signed(bus.op) & bus.b[WIDTH-1];
        a_mag  = a_neg ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;
        prod   = {acc_q, shr_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -shr_q : shr_q;
        rem_s  = rneg_q ? -acc_q : acc_q;
    end

    // Next-state logic for the FSM, datapath and HI/LO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shr_d   = shr_q;
        opb_d   = opb_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == MDU_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == MDU_MTLO) begin
                        lo_d = bus.a;
                    end else if (op_is_arith(bus.op)) begin
                        acc_d   = '0;
                        shr_d   = a_mag;
                        opb_d   = b_mag;
                        div_d   = bus.op[1];
                        // a zero divisor keeps the all-ones quotient
                        neg_d   = (a_neg ^ b_neg) & (|bus.b);
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                shr_d = step_shr;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            shr_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shr_q   <= shr_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo
// Directed cases plus random ops against an arithmetic reference model.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi,lo} from plain integer arithmetic
    function automatic logic [63:0] ref_res(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MDU_MULT: begin
                p = sx * sy;
                return p;
            end
            MDU_MULTU: return {32'b0, x} * {32'b0, y};
            MDU_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            MDU_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present one request for one edge, then scramble the inputs
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Count busy cycles until done, then measure the done pulse width
    task automatic wait_done(output int bcyc, output int dcyc, output bit to);
        bcyc = 0;
        dcyc = 0;
        to   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy) bcyc++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!to) begin
            while (bus.done && dcyc < 5) begin
                dcyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        total++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold hi=%h lo=%h busy=%b done=%b want 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle hi=%h lo=%h busy=%b done=%b want 0", bus.hi, bus.lo, bus.busy, bus.done);
        end
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    task automatic test_multu_max();
        int bc, dc;
        bit to;
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            bad++;
            $display("FAIL multu_hold hi=%h lo=%h want 0", bus.hi, bus.lo);
        end
        wait_done(bc, dc, to);
        total++;
        if (to || bc != 33) begin
            bad++;
            $display("FAIL multu_busy cycles=%0d timeout=%b want 33", bc, to);
        end
        total++;
        if (dc != 1) begin
            bad++;
            $display("FAIL multu_done_width got=%0d want 1", dc);
        end
        total++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1) begin
            bad++;
            $display("FAIL multu_res hi=%h lo=%h want fffffffe 00000001", bus.hi, bus.lo);
        end
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6];
        logic [31:0] av  [6];
        logic [31:0] bv  [6];
        logic [31:0] wh  [6];
        logic [31:0] wl  [6];
        int bc, dc;
        bit to;
        ops[0] = MDU_MULT; av[0] = 32'hFFFF_FFFD; bv[0] = 32'd7;
        wh[0] = 32'hFFFF_FFFF; wl[0] = 32'hFFFF_FFEB;
        ops[1] = MDU_MULT; av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000;
        wh[1] = 32'h4000_0000; wl[1] = 32'h0;
        ops[2] = MDU_DIV; av[2] = 32'hFFFF_FFF9; bv[2] = 32'd2;
        wh[2] = 32'hFFFF_FFFF; wl[2] = 32'hFFFF_FFFD;
        ops[3] = MDU_DIVU; av[3] = 32'd7; bv[3] = 32'd0;
        wh[3] = 32'd7; wl[3] = 32'hFFFF_FFFF;
        ops[4] = MDU_DIV; av[4] = 32'h8000_0000; bv[4] = 32'hFFFF_FFFF;
        wh[4] = 32'h0; wl[4] = 32'h8000_0000;
        ops[5] = MDU_DIV; av[5] = 32'hFFFF_FFF0; bv[5] = 32'd0;
        wh[5] = 32'hFFFF_FFF0; wl[5] = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], av[i], bv[i]);
            wait_done(bc, dc, to);
            total++;
            if (to || bc != 33 || bus.hi !== wh[i] || bus.lo !== wl[i]) begin
                bad++;
                $display("FAIL directed_%0d hi=%h lo=%h busy=%0d to=%b want %h %h 33",
                         i, bus.hi, bus.lo, bc, to, wh[i], wl[i]);
            end
        end
        exp_hi = wh[5];
        exp_lo = wl[5];
    endtask

    task automatic test_mthi();
        issue(MDU_MTHI, 32'h1234, 32'h0);
        total++;
        if (bus.hi !== 32'h1234 || bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL mthi hi=%h lo=%h busy=%b done=%b want 00001234 %h 0 0",
                     bus.hi, bus.lo, bus.busy, bus.done, exp_lo);
        end
        exp_hi = 32'h1234;
    endtask

    task automatic test_mtlo_busy();
        int bc, dc;
        bit to;
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_MTLO;
        bus.a     = 32'h55;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.lo !== exp_lo || bus.hi !== exp_hi || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mtlo_busy lo=%h hi=%h busy=%b want %h %h 1", bus.lo, bus.hi, bus.busy, exp_lo, exp_hi);
        end
        wait_done(bc, dc, to);
        total++;
        if (to || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            bad++;
            $display("FAIL mtlo_divu lo=%h hi=%h to=%b want 0000000e 00000002", bus.lo, bus.hi, to);
        end
        exp_hi = 32'd2;
        exp_lo = 32'd14;
    endtask

    task automatic test_reset_abort();
        int bc, dc, seen;
        bit to;
        issue(MDU_MULTU, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre busy=%b want 1", bus.busy);
        end
        #2 rstn = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_async busy=%b hi=%h lo=%h done=%b want 0", bus.busy, bus.hi, bus.lo, bus.done);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_resume activity_cycles=%0d want 0", seen);
        end
        issue(MDU_MULTU, 32'd3, 32'd5);
        wait_done(bc, dc, to);
        total++;
        if (to || bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL abort_rerun lo=%h hi=%h to=%b want 0000000f 0", bus.lo, bus.hi, to);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd15;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [63:0] r;
        int bc, dc;
        bit to;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            issue(o, x, y);
            if (o[2] == 1'b0) begin
                r = ref_res(o, x, y);
                wait_done(bc, dc, to);
                exp_hi = r[63:32];
                exp_lo = r[31:0];
                total++;
                if (to || bc != 33 || dc != 1 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                    bad++;
                    $display("FAIL rand_%0d op=%0d a=%h b=%h hi=%h lo=%h busy=%0d done=%0d want %h %h",
                             i, o, x, y, bus.hi, bus.lo, bc, dc, exp_hi, exp_lo);
                end
            end else begin
                if (o == MDU_MTHI) exp_hi = x;
                if (o == MDU_MTLO) exp_lo = x;
                total++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
                    bad++;
                    $display("FAIL rand_%0d op=%0d a=%h hi=%h lo=%h busy=%b want %h %h 0",
                             i, o, x, bus.hi, bus.lo, bus.busy, exp_hi, exp_lo);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multu_max();
        test_directed();
        test_mthi();
        test_mtlo_busy();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Operand A comes from the register file rs read port. Operand B is the ALU operand-B mux output (rt or extended immediate).
- HI/LO outputs are extra sources for the register write-back data select (mfhi/mflo).
- Exposes a busy flag; the controller stalls PC/writes on busy when an mfhi/mflo or new mult/div follows.

Parameters:
WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH.

Ports:
clk  in  1  rising-edge clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled at rising edge
op  in  3  operation code (package constants)
a  in  WIDTH  operand A (rs value); multiplicand / dividend / MTHI-MTLO source
b  in  WIDTH  operand B (operand-B mux output); multiplier / divisor
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse in the cycle HI/LO take the final result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: clk is one clock; reset is asynchronous and active-low (rstn). While rstn=0, immediately force hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal accumulators=0.
- Op codes:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 110/111 reserved, ignored (no state change).
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - MTHI: hi<=a at that edge. MTLO: lo<=a at that edge. Stay IDLE, busy stays 0, no done pulse.
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes (abs for signed ops, raw for unsigned), latch result-sign flags, counter<=0, busy<=1, go to CALC.
- CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle. counter increments each step. After step WIDTH (counter=WIDTH-1 on the edge), go to FIX.
- FIX (one cycle):
  - Apply sign correction.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi (product upper / remainder) and lo (product lower / quotient). Pulse done=1, busy<=0, return to IDLE.
- Latency: accept edge E0. busy=1 after E0 through E0+WIDTH+1. hi/lo updated and done=1 after edge E0+WIDTH+1 (33 cycles for WIDTH=32). done deasserts on the following edge.
- hi/lo hold their old values during CALC; only FIX, MTHI and MTLO modify them.
- start while busy=1: ignored entirely, including MTHI/MTLO. The controller must stall until busy=0.
- start in the same cycle as FIX: ignored. A new op is accepted only when state=IDLE.
- Divide by zero (b=0): no exception. Run the full latency, then lo=all ones, hi=a (unsigned dividend, unmodified, for both DIV and DIVU).
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special case.
- Magnitude of 0x80000000 is 0x80000000 interpreted unsigned. Internal datapath width is WIDTH+1 for the division remainder.
- op and operands are sampled only at accept. Later changes on a/b/op are don't-care.
- rstn low mid-operation aborts immediately with no done pulse. The operation does not resume after reset release.

Decomposition:
- Shared package mdu_pkg:
  - op code constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
  - state encoding (IDLE/CALC/FIX)
  - WIDTH default
- One natural sub-module: mdu_step. Combinational single-iteration core that takes accumulator/shift register, operand and mode, and returns the next accumulator/shift register for mult or div. The top holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- Reset then idle: rstn=0 -> hi=0, lo=0, busy=0, done=0. Release and wait 5 cycles -> unchanged.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 while idle -> hi=0x1234 next edge, busy stays 0. Start DIVU, then on cycle 5 issue MTLO a=0x55 -> ignored; lo holds until FIX, then takes the quotient.
- Start MULTU 3*5, drive rstn=0 at cycle 10 -> busy, hi and lo go to 0 asynchronously. After release, no done pulse; an issued MULTU 3*5 completes with lo=15, hi=0.
